// File: rtl/pending_priority_encoder.sv
// Sticky-pending N-input priority encoder with a registered valid/ack grant handshake.
// Define PENC_ROUND_ROBIN_EN for rotating-pointer arbitration instead of fixed priority.
module pending_priority_encoder #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx,
  input  logic         ack,
  output logic [N-1:0] pend,
  output logic         ovf
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   idx_q, idx_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   clr;
  logic [N-1:0]   cap;
  logic           sel_found;
  logic [W-1:0]   sel_idx;
  logic           ack_eff;

  assign ack_eff = (state_q == StGrant) && ack;
  assign cap     = en ? req : '0;

  always_comb begin
    clr = '0;
    if (ack_eff) clr[idx_q] = 1'b1;
  end

  // A new request on a bit being cleared this cycle re-arms it and is not an overflow.
  assign pend_d = (pend_q & ~clr) | cap;
  assign ovf_d  = |(cap & pend_q & ~clr);

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Search downward from ptr, wrapping modulo N.
  always_comb begin
    logic [W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q - W'(i);
      if (!sel_found && pend_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ack_eff) ptr_d = idx_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= W'(N - 1);
    else     ptr_q <= ptr_d;
  end
`else
  // Highest set index wins: later loop iterations override earlier ones.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) sel_idx = W'(i);
    end
    sel_found = |pend_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid = (state_q == StGrant);
  assign idx   = idx_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed-vector bench for pending_priority_encoder (N=8), fixed or round-robin build.
module tb_pending_priority_encoder;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

`ifdef PENC_ROUND_ROBIN_EN
  localparam logic [2:0] EnIdx = 3'd2;  // ptr sits at 2 after acking index 3
`else
  localparam logic [2:0] EnIdx = 3'd3;
`endif

  logic         clk = 1'b0;
  logic         rst, en, ack;
  logic [N-1:0] req;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] pend;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  pending_priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .valid (valid),
    .idx   (idx),
    .ack   (ack),
    .pend  (pend),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic       e_valid;
    logic [2:0] e_idx;
    logic [7:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic a);
    @(negedge clk);
    rst = r; en = e; req = q; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst en req ack | valid idx pend ovf  (expected after the edge)
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 3'd0, 8'h00, 0};  // reset
    vecs[1]  = '{0, 1, 8'h01, 1, 0, 3'd0, 8'h01, 0};  // capture; ack while idle ignored
    vecs[2]  = '{0, 1, 8'h00, 0, 1, 3'd0, 8'h01, 0};  // grant 2 cycles after req
    vecs[3]  = '{0, 1, 8'h00, 0, 1, 3'd0, 8'h01, 0};
    vecs[4]  = '{0, 1, 8'h00, 1, 0, 3'd0, 8'h00, 0};
    vecs[5]  = '{0, 1, 8'h00, 0, 0, 3'd0, 8'h00, 0};
    vecs[6]  = '{0, 1, 8'h92, 0, 0, 3'd0, 8'h92, 0};  // priority 7,4,1
    vecs[7]  = '{0, 1, 8'h00, 0, 1, 3'd7, 8'h92, 0};
    vecs[8]  = '{0, 1, 8'h00, 1, 0, 3'd7, 8'h12, 0};
    vecs[9]  = '{0, 1, 8'h00, 0, 1, 3'd4, 8'h12, 0};
    vecs[10] = '{0, 1, 8'h00, 1, 0, 3'd4, 8'h02, 0};
    vecs[11] = '{0, 1, 8'h00, 0, 1, 3'd1, 8'h02, 0};
    vecs[12] = '{0, 1, 8'h00, 1, 0, 3'd1, 8'h00, 0};
    vecs[13] = '{0, 1, 8'h00, 0, 0, 3'd1, 8'h00, 0};  // idx holds while idle
    vecs[14] = '{0, 1, 8'h04, 0, 0, 3'd1, 8'h04, 0};  // hold / no pre-emption
    vecs[15] = '{0, 1, 8'h00, 0, 1, 3'd2, 8'h04, 0};
    vecs[16] = '{0, 1, 8'h40, 0, 1, 3'd2, 8'h44, 0};
    vecs[17] = '{0, 1, 8'h00, 0, 1, 3'd2, 8'h44, 0};
    vecs[18] = '{0, 1, 8'h00, 1, 0, 3'd2, 8'h40, 0};
    vecs[19] = '{0, 1, 8'h00, 0, 1, 3'd6, 8'h40, 0};
    vecs[20] = '{0, 1, 8'h00, 1, 0, 3'd6, 8'h00, 0};
    vecs[21] = '{0, 1, 8'h08, 0, 0, 3'd6, 8'h08, 0};  // collision / overflow
    vecs[22] = '{0, 1, 8'h00, 0, 1, 3'd3, 8'h08, 0};
    vecs[23] = '{0, 1, 8'h08, 1, 0, 3'd3, 8'h08, 0};  // set wins, no ovf
    vecs[24] = '{0, 1, 8'h00, 0, 1, 3'd3, 8'h08, 0};
    vecs[25] = '{0, 1, 8'h08, 0, 1, 3'd3, 8'h08, 1};  // ovf pulse
    vecs[26] = '{0, 1, 8'h00, 0, 1, 3'd3, 8'h08, 0};
    vecs[27] = '{0, 1, 8'h00, 1, 0, 3'd3, 8'h00, 0};
    vecs[28] = '{0, 1, 8'h00, 0, 0, 3'd3, 8'h00, 0};
    vecs[29] = '{0, 0, 8'hFF, 0, 0, 3'd3, 8'h00, 0};  // en gating
    vecs[30] = '{0, 0, 8'hFF, 0, 0, 3'd3, 8'h00, 0};
    vecs[31] = '{0, 1, 8'h0F, 0, 0, 3'd3, 8'h0F, 0};
    vecs[32] = '{0, 0, 8'hFF, 0, 1, EnIdx, 8'h0F, 0}; // grant still proceeds with en=0
    vecs[33] = '{0, 1, 8'h08, 0, 1, EnIdx, 8'h0F, 1};
    vecs[34] = '{1, 1, 8'hFF, 0, 0, 3'd0, 8'h00, 0};  // reset mid-grant wins over capture
    vecs[35] = '{0, 0, 8'h00, 0, 0, 3'd0, 8'h00, 0};

    rst = 1'b1; en = 1'b0; req = '0; ack = 1'b0;

    for (int v = 0; v < 36; v++) begin
      step(vecs[v].rst, vecs[v].en, vecs[v].req, vecs[v].ack);
      check($sformatf("vec%0d.valid", v), 32'(valid), 32'(vecs[v].e_valid));
      check($sformatf("vec%0d.idx", v),   32'(idx),   32'(vecs[v].e_idx));
      check($sformatf("vec%0d.pend", v),  32'(pend),  32'(vecs[v].e_pend));
      check($sformatf("vec%0d.ovf", v),   32'(ovf),   32'(vecs[v].e_ovf));
    end

    // Bounded wait for a grant after a single pulse; must land exactly 2 edges later.
    begin
      int waited;
      step(1'b0, 1'b1, 8'h20, 1'b0);
      waited = 1;
      step(1'b0, 1'b1, 8'h00, 1'b0);
      while (!valid && waited < 8) begin
        step(1'b0, 1'b1, 8'h00, 1'b0);
        waited++;
      end
      check("pulse.latency", 32'(waited), 32'd1);
      check("pulse.idx", 32'(idx), 32'd5);
      step(1'b0, 1'b1, 8'h00, 1'b1);
      check("pulse.ack_valid", 32'(valid), 32'd0);
      check("pulse.ack_pend", 32'(pend), 32'h00);
    end

`ifdef PENC_ROUND_ROBIN_EN
    // Fairness: all requests held high, ack tied high.
    begin
      logic [2:0] exp_idx;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      check("rr.first_idle", 32'(valid), 32'd0);
      exp_idx = 3'd7;
      for (int g = 0; g < 16; g++) begin
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        check($sformatf("rr.grant%0d.valid", g), 32'(valid), 32'd1);
        check($sformatf("rr.grant%0d.idx", g), 32'(idx), 32'(exp_idx));
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        check($sformatf("rr.gap%0d.valid", g), 32'(valid), 32'd0);
        exp_idx = exp_idx - 3'd1;
      end
      check("rr.pend_full", 32'(pend), 32'hFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pending_priority_encoder.md
# pending_priority_encoder

Parametrised N-input, log2(N)-output priority encoder with request latching and a valid/ack handshake, for multi-source event and interrupt indexing.
- Requests are captured into a sticky pending register.
- The highest-priority pending index is presented registered and held stable until the consumer acknowledges it; the acknowledge clears that pending bit.
- It is the sequential, parametrised successor to the team's combinational 4-to-2 and 8-to-3 encoders, with input 0 carrying the lowest priority in the default mode.

## Interface
- N, default 8: number of request inputs; power of two, 2 to 64.
- W, localparam, $clog2(N): index width.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, req is ignored.
- req  input  N  request lines, sampled every clk edge while en=1 (level or pulse).
- valid  output  1  idx holds a granted pending request.
- idx  output  W  granted request index; stable while valid=1.
- ack  input  1  consumer accepts idx; effective only when valid=1.
- pend  output  N  current pending register.
- ovf  output  1  one-cycle pulse: a request hit a bit that was already pending.

## Operation
Pending register update, every edge:
- pend_next = (pend & ~clr) | (en ? req : 0).
- clr is one-hot at idx when valid & ack, otherwise 0.
- Set wins: if req[k]=1 arrives in the same cycle that ack clears bit k, pend[k] stays 1. This is not an overflow.

ovf:
- Registered pulse, high for one cycle.
- Fires when, for some k, en & req[k] & pend[k] & ~clr[k].

FSM, 2 states:
- IDLE: valid=0.
  - If pend != 0: load idx with the selected index, set valid=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: valid=1; idx, and the state, are frozen until ack.
  - On ack: clear pend[idx], set valid=0, return to IDLE.
  - Newly arriving higher-priority requests do not pre-empt the current grant.

Other rules:
- Selection is made from the registered pend only, never from raw req.
- ack while valid=0 is ignored and has no side effects.
- en=0 blocks capture only; pending bits continue to be granted and acknowledged normally.

## Timing
- Reset values: state=IDLE, pend=0, valid=0, idx=0, ovf=0; round-robin pointer = N-1.
- Reset mid-grant discards every pending bit and the outstanding grant on that edge.
- Latency: req high in cycle c gives pend[k]=1 in cycle c+1, then valid=1 with idx=k in cycle c+2.
- Handshake: with ack high in cycle g, valid=0 in g+1. If other bits are still pending, the next grant appears in g+2.
- Throughput: at most one grant every 2 cycles.
- idx keeps its last value while valid=0.
- No combinational path from req or ack to any output.

## Configuration
- Macro: PENC_ROUND_ROBIN_EN.
- Undefined (fixed priority):
  - The highest set index of pend wins (bit N-1 highest, bit 0 lowest).
  - No pointer register exists.
- Defined (round-robin):
  - A W-bit pointer ptr, reset to N-1, sets the search start.
  - Search order is ptr, ptr-1, … down to 0, then wraps to N-1 … ptr+1.
  - On each ack of index k: ptr <= (k-1) mod N, so index 0 wraps to N-1.
  - Every continuously pending source is granted within N grants.

## Test plan
- Reset and latency: N=8, en=1, req=8'h01 for 1 cycle → valid=1 and idx=0 exactly 2 cycles later; pend=8'h01 until ack; after ack, pend=0 and valid=0.
- Priority: req=8'h92 → grants idx=7, then 4, then 1 (ack each immediately), each valid separated by one low cycle. In round-robin mode the order is also 7, 4, 1.
- Hold and no pre-emption: idx=2 granted with ack withheld, then req[6] pulses → idx stays 2, pend=8'h44; after ack, the next grant is idx=6.
- Collision and overflow: with pend[3]=1 and idx=3 granted, req[3] pulses together with ack → pend[3] stays 1 and ovf=0. req[3] pulsed again while pending and ack low → ovf=1 for one cycle.
- en gating and mid-op reset: en=0 with req=8'hFF → pend unchanged. rst=1 during GRANT with pend=8'h0F → next cycle pend=0, valid=0, idx=0.
- Round-robin fairness (macro defined): req=8'hFF held high with ack tied high → idx sequence 7,6,5,4,3,2,1,0,7,…, one grant every 2 cycles.
